// File: rtl/free_list_if.sv
// free_list_if: dispatch/retire-side bundle for the physical register free list.
// master = rename/dispatch + retirement logic, slave = the free list itself.
interface free_list_if #(
  parameter int WIDTH   = 6,
  parameter int SS      = 2,
  parameter int SS_BITS = 1,
  parameter int CNT_W   = 6
);
  logic                        mispredict;
  logic [SS_BITS:0]            pop_cnt;
  logic [SS-1:0][WIDTH-1:0]    pd_dispatch;
  logic [CNT_W-1:0]            free_cnt;
  logic [SS_BITS:0]            push_cnt;
  logic [SS-1:0][WIDTH-1:0]    push_reg;
  logic                        underflow_err;
  logic                        overflow_err;

  modport master (
    output mispredict, pop_cnt, push_cnt, push_reg,
    input  pd_dispatch, free_cnt, underflow_err, overflow_err
  );

  modport slave (
    input  mispredict, pop_cnt, push_cnt, push_reg,
    output pd_dispatch, free_cnt, underflow_err, overflow_err
  );
endinterface

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical register tags with a retire-tracked
// shadow head for mispredict rollback. Define FREE_LIST_BYPASS_EN to forward same-cycle pushes.
module free_list #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int WIDTH         = 6,
  parameter int SS            = 2,
  parameter int SS_BITS       = 1
) (
  input logic        clk,
  input logic        rst_n,
  free_list_if.slave fl
);
  localparam int CAP = NUM_PHYS_REGS - 32;
  localparam int AW  = $clog2(CAP);
  localparam int PW  = AW + 1;

  logic [WIDTH-1:0] mem [CAP];
  logic [PW-1:0]    head, tail, ret_head;
  logic [PW-1:0]    reg_cnt, avail, pop_ext, push_ext;
  logic [PW-1:0]    pop_amt, push_amt, grow;
  logic             pop_ok, push_ok, underflow_now;
  logic             underflow_q, overflow_q;

  assign pop_ext  = PW'(fl.pop_cnt);
  assign push_ext = PW'(fl.push_cnt);
  assign reg_cnt  = tail - head;

  // A mispredict ignores the pop entirely, so it can never flag underflow.
  always_comb begin
    avail = reg_cnt;
`ifdef FREE_LIST_BYPASS_EN
    if (!fl.mispredict) avail = reg_cnt + push_ext;
`endif
    underflow_now = !fl.mispredict && (pop_ext > avail);
    pop_ok        = !fl.mispredict && !underflow_now;
    pop_amt       = pop_ok ? pop_ext : '0;
    grow          = reg_cnt + push_ext - pop_amt;
    push_ok       = (grow <= PW'(CAP));
    push_amt      = push_ok ? push_ext : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      ret_head    <= '0;
      tail        <= PW'(CAP);
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (fl.mispredict) head <= ret_head + push_ext;
      else               head <= head + pop_amt;
      tail        <= tail + push_amt;
      ret_head    <= ret_head + push_ext;
      underflow_q <= underflow_q | underflow_now;
      overflow_q  <= overflow_q | !push_ok;
    end
  end

  // Reset loads the architectural-overflow tags 32..32+CAP-1 in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CAP; i++) mem[i] <= WIDTH'(32 + i);
    end else begin
      for (int i = 0; i < SS; i++) begin
        if (push_ok && (PW'(i) < push_ext))
          mem[tail[AW-1:0] + AW'(i)] <= fl.push_reg[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < SS; i++) begin
      fl.pd_dispatch[i] = mem[head[AW-1:0] + AW'(i)];
`ifdef FREE_LIST_BYPASS_EN
      if (!fl.mispredict && (PW'(i) >= reg_cnt))
        fl.pd_dispatch[i] = fl.push_reg[SS_BITS'(PW'(i) - reg_cnt)];
`endif
    end
  end

  assign fl.free_cnt      = avail;
  assign fl.underflow_err = underflow_q;
  assign fl.overflow_err  = overflow_q;
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed scenarios plus legal random traffic, checked every cycle
// against a queue-based model of free tags and in-flight (allocated, unretired) tags.
module tb_free_list;
  localparam int NUM_PHYS_REGS = 64;
  localparam int WIDTH         = 6;
  localparam int SS            = 2;
  localparam int SS_BITS       = 1;
  localparam int CAP           = 32;
  localparam int CNT_W         = 6;

  logic clk = 1'b0;
  logic rst_n;

  free_list_if #(.WIDTH(WIDTH), .SS(SS), .SS_BITS(SS_BITS), .CNT_W(CNT_W)) fl_if ();

  free_list #(
    .NUM_PHYS_REGS(NUM_PHYS_REGS), .WIDTH(WIDTH), .SS(SS), .SS_BITS(SS_BITS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fl   (fl_if)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int fq[$];
  int inflight[$];
  bit m_uf, m_of;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    fq.delete();
    inflight.delete();
    for (int i = 0; i < CAP; i++) fq.push_back(32 + i);
    m_uf = 1'b0;
    m_of = 1'b0;
  endtask

  // Retirement frees the oldest in-flight allocations; a mispredict returns
  // whatever is still in flight to the front of the free queue.
  task automatic modelStep();
    int cnt, pc, pu, avail_m, popamt;
    cnt = fq.size();
    pc  = int'(fl_if.pop_cnt);
    pu  = int'(fl_if.push_cnt);
    for (int k = 0; k < pu; k++)
      if (inflight.size() > 0) void'(inflight.pop_front());
    if (fl_if.mispredict) begin
      if (cnt + pu > CAP) m_of = 1'b1;
      else for (int k = 0; k < pu; k++) fq.push_back(int'(fl_if.push_reg[k]));
      for (int k = inflight.size() - 1; k >= 0; k--) fq.push_front(inflight[k]);
      inflight.delete();
    end else begin
      avail_m = cnt;
`ifdef FREE_LIST_BYPASS_EN
      avail_m = cnt + pu;
`endif
      if (pc > avail_m) begin
        m_uf   = 1'b1;
        popamt = 0;
      end else begin
        popamt = pc;
      end
      if (cnt - popamt + pu > CAP) m_of = 1'b1;
      else for (int k = 0; k < pu; k++) fq.push_back(int'(fl_if.push_reg[k]));
      for (int k = 0; k < popamt; k++) inflight.push_back(fq.pop_front());
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else        modelStep();
  end

  task automatic checkModel();
    int exp_cnt, base, exp_tag;
    base    = fq.size();
    exp_cnt = base;
`ifdef FREE_LIST_BYPASS_EN
    if (!fl_if.mispredict) exp_cnt = base + int'(fl_if.push_cnt);
`endif
    checkOutput("free_cnt", int'(fl_if.free_cnt), exp_cnt);
    for (int i = 0; i < SS; i++) begin
      if (i < exp_cnt) begin
        exp_tag = (i < base) ? fq[i] : int'(fl_if.push_reg[i - base]);
        checkOutput($sformatf("pd_dispatch[%0d]", i), int'(fl_if.pd_dispatch[i]), exp_tag);
      end
    end
    checkOutput("underflow_err", int'(fl_if.underflow_err), int'(m_uf));
    checkOutput("overflow_err", int'(fl_if.overflow_err), int'(m_of));
  endtask

  always @(negedge clk) begin
    if (rst_n) checkModel();
  end

  task automatic setInputs(input bit mp, input int pop, input int push, input int r0, input int r1);
    fl_if.mispredict  = mp;
    fl_if.pop_cnt     = (SS_BITS + 1)'(pop);
    fl_if.push_cnt    = (SS_BITS + 1)'(push);
    fl_if.push_reg[0] = WIDTH'(r0);
    fl_if.push_reg[1] = WIDTH'(r1);
  endtask

  task automatic applyStimulus(input bit mp, input int pop, input int push, input int r0, input int r1);
    @(posedge clk);
    #1;
    setInputs(mp, pop, push, r0, r1);
  endtask

  task automatic doReset();
    @(negedge clk);
    setInputs(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
  endtask

  task automatic checkLiteral(input int cnt, input int t0, input int t1, input int uf, input int of);
    checkOutput("lit free_cnt", int'(fl_if.free_cnt), cnt);
    if (t0 >= 0) checkOutput("lit pd_dispatch[0]", int'(fl_if.pd_dispatch[0]), t0);
    if (t1 >= 0) checkOutput("lit pd_dispatch[1]", int'(fl_if.pd_dispatch[1]), t1);
    checkOutput("lit underflow_err", int'(fl_if.underflow_err), uf);
    checkOutput("lit overflow_err", int'(fl_if.overflow_err), of);
  endtask

  initial begin
    int mp, pop, push, maxp;
    rst_n = 1'b1;
    setInputs(0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #10 rst_n = 1'b1;

    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkLiteral(32, 32, 33, 0, 0);

    // Drain completely, then one pop too many.
    for (int c = 0; c < 16; c++) applyStimulus(0, 2, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    @(negedge clk);
    checkLiteral(0, -1, -1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkLiteral(0, -1, -1, 1, 0);

    applyStimulus(0, 0, 2, 5, 9);
`ifdef FREE_LIST_BYPASS_EN
    @(negedge clk);
    checkLiteral(2, 5, 9, 1, 0);
`endif
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkLiteral(2, 5, 9, 1, 0);

    // Rollback to the retire shadow pointer.
    doReset();
    applyStimulus(0, 2, 0, 0, 0);
    applyStimulus(0, 2, 0, 0, 0);
    applyStimulus(0, 2, 1, 40, 0);
    applyStimulus(1, 0, 1, 41, 0);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkLiteral(32, 34, 35, 0, 0);

    // Steady-state recycling wraps the pointers several times.
    applyStimulus(0, 2, 0, 0, 0);
    for (int c = 0; c < 40; c++)
      applyStimulus(0, 2, 2, $urandom_range(1, 63), $urandom_range(1, 63));
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkLiteral(30, -1, -1, 0, 0);

    // Legal random traffic: pushes never exceed the tags currently in flight.
    doReset();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      mp   = ($urandom_range(0, 15) == 0) ? 1 : 0;
      pop  = $urandom_range(0, 2);
      maxp = (inflight.size() < 2) ? inflight.size() : 2;
      push = $urandom_range(0, maxp);
      setInputs(mp[0], pop, push, $urandom_range(1, 63), $urandom_range(1, 63));
    end
    applyStimulus(0, 0, 0, 0, 0);

    // Pushing into a full list.
    doReset();
    applyStimulus(0, 0, 1, 7, 0);
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkLiteral(32, 32, 33, 0, 1);

    // Asynchronous reset between edges in the middle of a pop burst.
    applyStimulus(0, 2, 0, 0, 0);
    applyStimulus(0, 2, 0, 0, 0);
    applyStimulus(0, 2, 0, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkLiteral(32, 32, 33, 0, 0);
    setInputs(0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    @(negedge clk);
    checkLiteral(32, 32, 33, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register indices for the out-of-order core.
- Supplies up to SS new destination tags per cycle to rename/dispatch; these drive the RAT `pd_dispatch` inputs.
- Accepts up to SS freed tags per cycle from the retirement register file (`free_list_push` and `old_phys_reg` outputs).
- On branch mispredict it reclaims every tag allocated after the last retired instruction, by rolling the read pointer back to a retire-tracked shadow pointer.

Parameters:
- NUM_PHYS_REGS, 64, total physical registers. Capacity CAP = NUM_PHYS_REGS-32; CAP must be a power of two.
- WIDTH, NUM_PHYS_REGS_BITS (6), physical tag width.
- SS, SS_FACTOR (2), superscalar width.
- SS_BITS, SS_FACTOR_BITS (1), bits for SS-1; count ports are SS_BITS+1 wide.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mispredict  in  1  flush pulse from ROB, same cycle the RAT restores from the RRF.
- pop_cnt  in  SS_BITS+1  tags consumed by dispatch this cycle, 0..SS.
- pd_dispatch[SS]  out  WIDTH  next free tags; slot i = entry at head+i.
- free_cnt  out  log2(CAP)+1  current number of free tags.
- push_cnt  in  SS_BITS+1  freed tags returned this cycle, 0..SS (RRF free_list_push).
- push_reg[SS]  in  WIDTH  freed tags, packed from slot 0 (RRF old_phys_reg).
- underflow_err  out  1  sticky: pop_cnt > free_cnt seen.
- overflow_err  out  1  sticky: push would exceed CAP.

Behaviour:
- State:
  - mem[CAP] of WIDTH bits.
  - Pointers head, tail and ret_head, each log2(CAP)+1 bits (MSB = wrap bit).
  - Addressing uses the low log2(CAP) bits and wraps modulo CAP.
- Asynchronous reset (rst_n low):
  - mem[i] = 32+i.
  - head = ret_head = 0; tail = CAP with wrap bit set, i.e. full.
  - Error flags 0.
  - Outputs after reset: pd_dispatch[i] = 32+i, free_cnt = CAP.
  - Reset asserted mid-operation discards all state immediately.
- free_cnt = tail - head (pointer subtraction); combinational from registers. pd_dispatch is combinational from mem/head; zero-latency read.
- Pop:
  - head_next = head + pop_cnt.
  - Slots i >= free_cnt present don't-care values; dispatch must not consume them.
  - If pop_cnt > free_cnt: no pop occurs, head holds, underflow_err sets.
- Push:
  - For i < push_cnt, mem[tail+i] <= push_reg[i]; tail_next = tail + push_cnt.
  - Slots i >= push_cnt are ignored.
  - If free_cnt - pop + push_cnt > CAP: no push occurs, overflow_err sets. This is unreachable in a correct core.
- Retire shadow:
  - Each retired rd!=0 instruction frees exactly one tag and consumed exactly one tag at dispatch, so push_cnt equals the retire allocation count.
  - ret_head_next = ret_head + push_cnt every cycle.
- Mispredict (highest priority on head):
  - head <= ret_head + push_cnt; the same-cycle retire is included.
  - pop_cnt that cycle is ignored.
  - Push in the same cycle still writes and advances tail.
  - Result: free_cnt = CAP - (in-flight committed-but-not-yet-pushed tags), which is 0 in normal use, i.e. free_cnt = CAP.
- Simultaneous push and pop:
  - Both apply.
  - Pushed tags are not visible on pd_dispatch until the next cycle (unless bypass is enabled).
  - free_cnt_next = free_cnt + push_cnt - pop_cnt.
- Wrap-around: pointers wrap naturally; full vs empty is distinguished by the wrap bit.
- Tag 0 is never stored. Pushing 0 is a protocol violation; no check.
- Error flags clear only on reset.

Optional Feature:
- Macro: FREE_LIST_BYPASS_EN.
- When defined:
  - Same-cycle pushes are forwarded.
  - Effective count = free_cnt + push_cnt; the free_cnt output reports this effective count.
  - pd_dispatch slot i >= registered count takes push_reg[i - count].
  - head advances normally; bypassed tags are still written to mem and later popped past.
  - Bypass is disabled during mispredict.
- When undefined: behaviour is exactly as above; no forwarding.

Test Plan:
- Reset, idle 2 cycles -> free_cnt=32, pd_dispatch={32,33}, both err flags 0.
- pop_cnt=2 for 16 cycles -> free_cnt=0 after the 16th edge. Then pop_cnt=1 -> underflow_err=1, head unchanged.
- From empty, push_cnt=2 push_reg={5,9} -> next cycle free_cnt=2, pd_dispatch={5,9}. With FREE_LIST_BYPASS_EN, free_cnt=2 and {5,9} appear in the push cycle.
- Pop 6 tags (2/cycle); push_cnt=1 push_reg=40 in the same cycle as the 3rd pop; assert mispredict with push_cnt=1 push_reg=41 -> head = ret_head = 2, free_cnt = 32 - 2 + 2 = 32, pd_dispatch = {34,35}.
- Steady push_cnt=2/pop_cnt=2 for 40 cycles -> pointers wrap past CAP, free_cnt constant, pd_dispatch returns tags in push order, no errors.
- Assert rst_n low mid-burst, asynchronously between edges -> outputs immediately return to free_cnt=32, pd_dispatch={32,33}, errors cleared.
